// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use and multdiv interlocks, branch flush,
// and multi-cycle multdiv issue/writeback sequencing with a watchdog timeout.
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] fd_readRegA,
  input  logic [4:0] fd_readRegB,
  input  logic       fd_usesA,
  input  logic       fd_usesB,
  input  logic [4:0] fd_rd,
  input  logic       fd_writes_rd,
  input  logic       fd_is_md,
  input  logic       dx_is_lw,
  input  logic [4:0] dx_rd,
  input  logic       branch_taken,
  input  logic       multdiv_resultRDY,
  output logic       stall_pc,
  output logic       stall_fd,
  output logic       bubble_dx,
  output logic       flush_fd,
  output logic       md_start,
  output logic       md_wb,
  output logic [4:0] md_rd,
  output logic       md_busy,
  output logic       md_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MD_TIMEOUT - 1);

  state_t           r_state;
  logic [4:0]       r_md_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_md_error;

  logic w_idle;
  logic w_load_use;
  logic w_md_dep;
  logic w_md_hz;
  logic w_stall;
  logic w_md_start;

  assign w_idle = (r_state == IDLE);

  assign w_load_use = dx_is_lw & (dx_rd != 5'd0) &
                      ((fd_usesA & (fd_readRegA == dx_rd)) |
                       (fd_usesB & (fd_readRegB == dx_rd)));

  // md_rd==0 marks an in-flight op with no architectural destination.
  assign w_md_dep = (r_md_rd != 5'd0) &
                    ((fd_usesA     & (fd_readRegA == r_md_rd)) |
                     (fd_usesB     & (fd_readRegB == r_md_rd)) |
                     (fd_writes_rd & (fd_rd       == r_md_rd)));

  // fd_is_md alone stalls while the single multdiv unit is occupied.
  assign w_md_hz    = ~w_idle & (w_md_dep | fd_is_md);
  assign w_stall    = (w_load_use | w_md_hz) & ~branch_taken;
  assign w_md_start = fd_is_md & w_idle & ~w_load_use & ~branch_taken;

  assign stall_pc  = ~reset & w_stall;
  assign stall_fd  = ~reset & w_stall;
  assign bubble_dx = ~reset & (w_stall | branch_taken);
  assign flush_fd  = ~reset & branch_taken;
  assign md_start  = ~reset & w_md_start;
  assign md_wb     = ~reset & (r_state == MD_DONE);
  assign md_busy   = ~reset & ~w_idle;
  assign md_error  = ~reset & r_md_error;
  assign md_rd     = reset ? 5'd0 : r_md_rd;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_md_rd    <= 5'd0;
      r_cnt      <= '0;
      r_md_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_md_start) begin
            r_md_rd <= fd_writes_rd ? fd_rd : 5'd0;
            r_cnt   <= '0;
            r_state <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (multdiv_resultRDY) begin
            r_state <= MD_DONE;
          end else if (r_cnt == TMO_LAST) begin
            r_md_error <= 1'b1;
            r_state    <= IDLE;
          end
        end
        MD_DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: hand-computed expected output vectors
// checked with immediate assertions.
module tb_hazard_stall_ctrl;

  logic       clock;
  logic       reset;
  logic [4:0] fd_readRegA, fd_readRegB, fd_rd, dx_rd;
  logic       fd_usesA, fd_usesB, fd_writes_rd, fd_is_md;
  logic       dx_is_lw, branch_taken, multdiv_resultRDY;
  logic       stall_pc, stall_fd, bubble_dx, flush_fd;
  logic       md_start, md_wb, md_busy, md_error;
  logic [4:0] md_rd;

  int vectors     = 0;
  int miscompares = 0;

  // {stall_pc, stall_fd, bubble_dx, flush_fd, md_start, md_wb, md_busy, md_error}
  localparam logic [7:0] NONE  = 8'b0000_0000;
  localparam logic [7:0] STALL = 8'b1110_0000;
  localparam logic [7:0] FLUSH = 8'b0011_0000;
  localparam logic [7:0] START = 8'b0000_1000;
  localparam logic [7:0] WB    = 8'b0000_0100;
  localparam logic [7:0] BUSY  = 8'b0000_0010;
  localparam logic [7:0] ERR   = 8'b0000_0001;

  logic [7:0] outs;
  assign outs = {stall_pc, stall_fd, bubble_dx, flush_fd, md_start, md_wb, md_busy, md_error};

  hazard_stall_ctrl #(.MD_TIMEOUT(40), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .fd_readRegA(fd_readRegA), .fd_readRegB(fd_readRegB),
    .fd_usesA(fd_usesA), .fd_usesB(fd_usesB),
    .fd_rd(fd_rd), .fd_writes_rd(fd_writes_rd), .fd_is_md(fd_is_md),
    .dx_is_lw(dx_is_lw), .dx_rd(dx_rd),
    .branch_taken(branch_taken), .multdiv_resultRDY(multdiv_resultRDY),
    .stall_pc(stall_pc), .stall_fd(stall_fd), .bubble_dx(bubble_dx),
    .flush_fd(flush_fd), .md_start(md_start), .md_wb(md_wb),
    .md_rd(md_rd), .md_busy(md_busy), .md_error(md_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    fd_readRegA = 5'd0; fd_readRegB = 5'd0; fd_rd = 5'd0; dx_rd = 5'd0;
    fd_usesA = 1'b0; fd_usesB = 1'b0; fd_writes_rd = 1'b0; fd_is_md = 1'b0;
    dx_is_lw = 1'b0; branch_taken = 1'b0; multdiv_resultRDY = 1'b0;
  endtask

  initial begin
    // Reset forces every output low even with hazard-producing inputs.
    clear_inputs();
    reset = 1'b1;
    fd_is_md = 1'b1; branch_taken = 1'b1; dx_is_lw = 1'b1; dx_rd = 5'd3;
    fd_readRegA = 5'd3; fd_usesA = 1'b1;
    #1;
    check("reset_outs", outs, NONE);
    check("reset_md_rd", {3'b0, md_rd}, 8'd0);
    tick(); tick();
    reset = 1'b0; clear_inputs();
    #1;
    check("post_reset", outs, NONE);

    // Load-use on port A: one stall cycle, then clear.
    tick();
    dx_is_lw = 1'b1; dx_rd = 5'd5; fd_readRegA = 5'd5; fd_usesA = 1'b1;
    #1; check("lu_a", outs, STALL);
    tick();
    dx_is_lw = 1'b0;
    #1; check("lu_a_release", outs, NONE);

    // Register 0 and unused read port never hazard.
    tick(); clear_inputs();
    dx_is_lw = 1'b1; dx_rd = 5'd0; fd_readRegA = 5'd0; fd_usesA = 1'b1;
    #1; check("lu_r0", outs, NONE);
    tick(); clear_inputs();
    dx_is_lw = 1'b1; dx_rd = 5'd7; fd_readRegB = 5'd7; fd_usesB = 1'b0;
    #1; check("lu_b_unused", outs, NONE);
    tick();
    fd_usesB = 1'b1;
    #1; check("lu_b_used", outs, STALL);

    // Multdiv issue to r9, dependent stalls through MD_DONE.
    tick(); clear_inputs();
    fd_is_md = 1'b1; fd_writes_rd = 1'b1; fd_rd = 5'd9;
    #1; check("md_start", outs, START);
    tick(); clear_inputs();
    fd_readRegA = 5'd3; fd_usesA = 1'b1;
    #1; check("md_busy_indep", outs, BUSY);
    check("md_rd_9", {3'b0, md_rd}, 8'd9);
    tick();
    fd_is_md = 1'b1; fd_rd = 5'd4; fd_writes_rd = 1'b1;
    #1; check("md_struct", outs, STALL | BUSY);
    tick(); clear_inputs();
    fd_readRegA = 5'd9; fd_usesA = 1'b1;
    for (int i = 0; i < 14; i++) begin
      #1; check($sformatf("md_dep_%0d", i), outs, STALL | BUSY);
      tick();
    end
    multdiv_resultRDY = 1'b1;
    #1; check("md_rdy_cycle", outs, STALL | BUSY);
    tick();
    // RDY held into MD_DONE must be ignored.
    #1; check("md_done", outs, STALL | WB | BUSY);
    tick();
    #1; check("md_release", outs, NONE);
    check("md_rd_hold", {3'b0, md_rd}, 8'd9);
    tick();
    #1; check("rdy_in_idle", outs, NONE);
    multdiv_resultRDY = 1'b0;

    // Branch overrides load-use and blocks a new md_start.
    tick(); clear_inputs();
    dx_is_lw = 1'b1; dx_rd = 5'd6; fd_readRegB = 5'd6; fd_usesB = 1'b1;
    branch_taken = 1'b1; fd_is_md = 1'b1;
    #1; check("br_over_lu", outs, FLUSH);
    tick();
    #1; check("br_no_start", outs, FLUSH);
    tick(); clear_inputs();
    fd_is_md = 1'b1; fd_writes_rd = 1'b1; fd_rd = 5'd12;
    #1; check("md2_start", outs, START);
    tick(); clear_inputs();
    fd_writes_rd = 1'b1; fd_rd = 5'd12;
    #1; check("md2_waw", outs, STALL | BUSY);
    tick(); clear_inputs();
    fd_readRegA = 5'd12; fd_usesA = 1'b1; branch_taken = 1'b1;
    #1; check("md2_branch", outs, FLUSH | BUSY);
    tick();
    multdiv_resultRDY = 1'b1;
    #1; check("md2_branch_rdy", outs, FLUSH | BUSY);
    tick(); clear_inputs();
    #1; check("md2_wb", outs, WB | BUSY);
    tick();
    #1; check("md2_idle", outs, NONE);

    // Timeout: exactly 40 MD_BUSY cycles, then sticky error and no writeback.
    tick(); clear_inputs();
    fd_is_md = 1'b1; fd_writes_rd = 1'b1; fd_rd = 5'd20;
    #1; check("tmo_start", outs, START);
    tick(); clear_inputs();
    for (int i = 0; i < 40; i++) begin
      #1; check($sformatf("tmo_busy_%0d", i), outs, BUSY);
      tick();
    end
    #1; check("tmo_expired", outs, ERR);
    tick();
    multdiv_resultRDY = 1'b1;
    #1; check("tmo_late_rdy", outs, ERR);
    tick();
    multdiv_resultRDY = 1'b0;
    #1; check("tmo_no_wb", outs, ERR);

    // Start with no destination: md_rd=0 disables dependency checks.
    tick();
    fd_is_md = 1'b1; fd_writes_rd = 1'b0; fd_rd = 5'd9;
    #1; check("nodest_start", outs, START | ERR);
    tick(); clear_inputs();
    fd_readRegA = 5'd9; fd_usesA = 1'b1; fd_readRegB = 5'd0; fd_usesB = 1'b1;
    #1; check("nodest_nodep", outs, BUSY | ERR);
    check("nodest_md_rd", {3'b0, md_rd}, 8'd0);
    multdiv_resultRDY = 1'b1;
    tick(); clear_inputs();
    #1; check("nodest_wb", outs, WB | BUSY | ERR);
    tick();

    // Reset mid-op abandons the multdiv and clears the error.
    fd_is_md = 1'b1; fd_writes_rd = 1'b1; fd_rd = 5'd9;
    #1; check("rst_start", outs, START | ERR);
    tick(); clear_inputs();
    #1; check("rst_busy", outs, BUSY | ERR);
    tick();
    reset = 1'b1; fd_readRegA = 5'd9; fd_usesA = 1'b1; fd_is_md = 1'b1;
    #1; check("rst_high", outs, NONE);
    tick();
    reset = 1'b0; clear_inputs(); multdiv_resultRDY = 1'b1;
    #1; check("rst_after", outs, NONE);
    check("rst_md_rd", {3'b0, md_rd}, 8'd0);
    tick();
    multdiv_resultRDY = 1'b0;
    #1; check("rst_no_wb", outs, NONE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
